// File: rtl/pc_sequencer.sv
// Fetch program counter: picks the next fetch address from redirect, decode
// jump, return-address-stack prediction or sequential flow, one cycle per update.
module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] BOOT_ADDRESS = '0,
  parameter int unsigned     RAS_DEPTH    = 4,
  parameter int unsigned     INSTR_BYTES  = 4
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               stall,
  input  logic                               redirect_valid,
  input  logic [XLEN-1:0]                    redirect_target,
  input  logic                               jump,
  input  logic [XLEN-1:0]                    jump_offset,
  input  logic                               call,
  input  logic                               ret,
  output logic [XLEN-1:0]                    instruction_addr,
  output logic [XLEN-1:0]                    ia_plus4,
  output logic                               predicted_return,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count
);

  localparam int unsigned     PTR_W     = $clog2(RAS_DEPTH);
  localparam int unsigned     CNT_W     = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] STEP      = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] HALF_MASK = ~XLEN'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc4_q, pc4_d;
  logic             pred_q, pred_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             push;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];

  // State register; RAS contents are deliberately left unreset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= BOOT_ADDRESS;
      pc4_q  <= BOOT_ADDRESS + STEP;
      pred_q <= 1'b0;
      cnt_q  <= '0;
      ptr_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      pc4_q  <= pc4_d;
      pred_q <= pred_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
    end
  end

  // Return address of the linking instruction is exactly the current ia_plus4.
  always_ff @(posedge clock) begin
    if (push) begin
      ras_q[ptr_d] <= pc4_q;
    end
  end

  // Next-PC selection in priority order; redirect overrides a stall.
  always_comb begin
    pc_d   = pc_q + STEP;
    pred_d = 1'b0;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    push   = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_target & HALF_MASK;
    end else if (stall) begin
      pc_d   = pc_q;
      pred_d = pred_q;
    end else if (jump) begin
      pc_d = pc_q + jump_offset;
      if (call) begin
        push  = 1'b1;
        ptr_d = ptr_q + 1'b1;
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
    end else if (ret && (cnt_q != '0)) begin
      pc_d   = ras_q[ptr_q];
      pred_d = 1'b1;
      ptr_d  = ptr_q - 1'b1;
      cnt_d  = cnt_q - 1'b1;
    end
    pc4_d = pc_d + STEP;
  end

  always_comb begin
    instruction_addr = pc_q;
    ia_plus4         = pc4_q;
    predicted_return = pred_q;
    ras_count        = cnt_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic against a queue-based reference model of the fetch PC and RAS.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall = 1'b0, redirect_valid = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic [31:0] redirect_target = '0, jump_offset = '0;
  logic [31:0] instruction_addr, ia_plus4;
  logic        predicted_return;
  logic [2:0]  ras_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc;
  logic        m_pred;
  logic [31:0] m_ras[$];

  wire [67:0] obs = {instruction_addr, ia_plus4, predicted_return, ras_count};

  pc_sequencer #(.XLEN(32), .BOOT_ADDRESS(32'h0), .RAS_DEPTH(4), .INSTR_BYTES(4)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .jump(jump), .jump_offset(jump_offset), .call(call), .ret(ret),
    .instruction_addr(instruction_addr), .ia_plus4(ia_plus4),
    .predicted_return(predicted_return), .ras_count(ras_count)
  );

  always #5 clock = ~clock;

  function automatic logic [67:0] exp_vec();
    return {m_pc, m_pc + 32'd4, m_pred, 3'(m_ras.size())};
  endfunction

  task automatic model_reset();
    m_pc   = 32'h0;
    m_pred = 1'b0;
    m_ras.delete();
  endtask

  // Reference: a bounded stack whose oldest entry falls off when a fifth is pushed.
  task automatic model_step();
    if (redirect_valid) begin
      m_pc   = {redirect_target[31:1], 1'b0};
      m_pred = 1'b0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (jump) begin
      if (call) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
      m_pc   = m_pc + jump_offset;
      m_pred = 1'b0;
    end else if (ret && m_ras.size() > 0) begin
      m_pc   = m_ras.pop_back();
      m_pred = 1'b1;
    end else begin
      m_pc   = m_pc + 32'd4;
      m_pred = 1'b0;
    end
  endtask

  task automatic idle();
    stall = 0; redirect_valid = 0; jump = 0; call = 0; ret = 0;
    redirect_target = '0; jump_offset = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic go_to(input logic [31:0] addr);
    idle(); redirect_valid = 1; redirect_target = addr;
    tick();
    idle();
  endtask

  task automatic test_reset();
    #3 reset_n = 0;
    model_reset();
    #10;
    n_tests++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL reset_hold got=%h exp=%h", obs, exp_vec());
    end
    @(posedge clock); #1 reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (instruction_addr !== 32'(4 * i) || ia_plus4 !== 32'(4 * i + 4) || obs !== exp_vec()) begin
        n_fail++; $display("FAIL seq_%0d got=%h exp=%h", i, obs, exp_vec());
      end
      if (i < 3) tick();
    end
    #2 reset_n = 0;
    model_reset();
    #1;
    n_tests++;
    if (instruction_addr !== 32'h0 || ia_plus4 !== 32'h4 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL async_reset got=%h exp=%h", obs, exp_vec());
    end
    @(posedge clock); #1 reset_n = 1;
  endtask

  task automatic test_jump_call_ret();
    go_to(32'h100);
    jump = 1; call = 1; jump_offset = 32'h40;
    tick(); idle();
    n_tests++;
    if (instruction_addr !== 32'h140 || ras_count !== 3'd1 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL call got=%h exp=%h", obs, exp_vec());
    end
    tick(); tick();
    ret = 1;
    tick(); idle();
    n_tests++;
    if (instruction_addr !== 32'h104 || predicted_return !== 1'b1 || ras_count !== 3'd0 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL ret got=%h exp=%h", obs, exp_vec());
    end
    tick();
    n_tests++;
    if (instruction_addr !== 32'h108 || predicted_return !== 1'b0 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL after_ret got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_ras_overflow();
    go_to(32'h1000);
    for (int i = 0; i < 5; i++) begin
      jump = 1; call = 1; jump_offset = 32'h100;
      tick();
    end
    idle();
    n_tests++;
    if (ras_count !== 3'd4 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL overflow_count got=%h exp=%h", obs, exp_vec());
    end
    for (int i = 0; i < 5; i++) begin
      ret = 1;
      tick();
      idle();
      n_tests++;
      if (obs !== exp_vec() || predicted_return !== (i < 4)) begin
        n_fail++; $display("FAIL overflow_ret_%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_stall_redirect();
    go_to(32'h500);
    jump = 1; call = 1; jump_offset = 32'h0;
    tick();
    go_to(32'h200);
    for (int i = 0; i < 3; i++) begin
      stall = 1; ret = 1;
      tick();
      n_tests++;
      if (instruction_addr !== 32'h200 || ras_count !== 3'd1 || obs !== exp_vec()) begin
        n_fail++; $display("FAIL stall_%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    ret = 0; redirect_valid = 1; redirect_target = 32'h301;
    tick(); idle();
    n_tests++;
    if (instruction_addr !== 32'h300 || ia_plus4 !== 32'h304 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL stall_redirect got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_priority_wrap();
    logic [2:0] cnt0;
    cnt0 = ras_count;
    redirect_valid = 1; redirect_target = 32'h10; jump = 1; call = 1; ret = 1; jump_offset = 32'h80;
    tick(); idle();
    n_tests++;
    if (instruction_addr !== 32'h10 || ras_count !== cnt0 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL priority got=%h exp=%h", obs, exp_vec());
    end
    jump = 1; jump_offset = 32'hFFFF_FFF0;
    tick(); idle();
    n_tests++;
    if (instruction_addr !== 32'h0 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL jump_wrap got=%h exp=%h", obs, exp_vec());
    end
    go_to(32'hFFFF_FFFC);
    n_tests++;
    if (ia_plus4 !== 32'h0 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL top_addr got=%h exp=%h", obs, exp_vec());
    end
    tick();
    n_tests++;
    if (instruction_addr !== 32'h0 || ia_plus4 !== 32'h4 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL seq_wrap got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      redirect_valid  = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom();
      stall           = ($urandom_range(0, 5) == 0);
      jump            = ($urandom_range(0, 3) == 0);
      call            = $urandom_range(0, 1) == 1;
      ret             = ($urandom_range(0, 2) == 0);
      jump_offset     = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 255) * 4) - 32'h200;
      tick();
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL random_%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_jump_call_ret();
    test_ras_overflow();
    test_stall_redirect();
    test_priority_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation fetch program counter for the 7-stage pipeline.
- Produces the fetch address each cycle and selects the next PC from four sources: execute-stage redirect, decode jump (PC-relative), return-address-stack (RAS) prediction, or sequential.
- Adds a circular RAS, a redirect path that takes effect during a stall, and a stall-consistent ia_plus4.

Parameters:
XLEN, 32, address/data width in bits
BOOT_ADDRESS, 32'h0000_0000, PC value loaded on reset
RAS_DEPTH, 4, number of RAS entries (power of two, >=2)
INSTR_BYTES, 4, sequential increment in bytes

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
stall  input  1  hold PC and RAS (ignored while redirect_valid=1)
redirect_valid  input  1  execute-stage correction (mispredict or jalr)
redirect_target  input  XLEN  corrected PC; bit 0 is forced to 0
jump  input  1  decode: PC-relative jump/branch taken for the instruction at instruction_addr
jump_offset  input  XLEN  signed byte offset, added to instruction_addr
call  input  1  decode: jump links (jal ra); qualified by jump
ret  input  1  decode: return hint (jalr x0, ra)
instruction_addr  output  XLEN  current fetch address (registered)
ia_plus4  output  XLEN  instruction_addr + INSTR_BYTES (registered)
predicted_return  output  1  instruction_addr was sourced from the RAS (registered)
ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries (registered)

Behaviour:
- Reset (reset_n=0, asynchronous, any time including mid-operation):
  - instruction_addr=BOOT_ADDRESS, ia_plus4=BOOT_ADDRESS+INSTR_BYTES.
  - predicted_return=0, ras_count=0, RAS top pointer=0.
  - RAS entry contents are don't-care.
- Next-PC priority, evaluated every cycle:
  1. redirect_valid → {redirect_target[XLEN-1:1],1'b0}. Applies even when stall=1. No RAS push/pop.
  2. stall → hold all state. No push/pop. predicted_return holds.
  3. jump → instruction_addr + jump_offset (modulo 2^XLEN, wrap silently). If call=1, push instruction_addr+INSTR_BYTES. A simultaneous ret is ignored (no pop).
  4. ret with ras_count>0 → next PC = RAS top entry; pop; predicted_return=1 next cycle.
  5. ret with ras_count=0 → sequential; no pop; count stays 0; predicted_return=0.
  6. Otherwise sequential: instruction_addr + INSTR_BYTES.
- call without jump is ignored.
- predicted_return=1 only in the cycle after a RAS-sourced update. Any other update clears it.
- ia_plus4 is always registered together with instruction_addr as next_pc+INSTR_BYTES, so ia_plus4 == instruction_addr+INSTR_BYTES holds in every cycle.
- Latency: one cycle from select inputs to the new instruction_addr. No combinational path from inputs to outputs.
- RAS is a circular buffer with a top pointer.
  - Push: pointer advances, entry written, ras_count = min(count+1, RAS_DEPTH).
  - Push when full: overwrites the oldest entry; count stays RAS_DEPTH.
  - Pop: reads the top entry, pointer retreats, count decrements.
  - Pointer wraps modulo RAS_DEPTH.
- Redirect does not flush the RAS. Upstream handles RAS repair.
- Address arithmetic is unsigned XLEN-bit and wraps at 2^XLEN (e.g. 32'hFFFF_FFFC + 4 → 0).

Test Plan:
- Reset and sequential: release reset_n with BOOT_ADDRESS=0, no controls → instruction_addr = 0, 4, 8, 12 on successive cycles; ia_plus4 = 4, 8, 12, 16. Assert reset_n=0 mid-cycle at addr 12 → outputs return to 0/4 immediately, without waiting for a clock edge.
- Jump/call/return: at addr 0x100, jump=1, call=1, offset=0x40 → addr 0x140, ras_count=1. At 0x148, ret=1 → addr 0x104, predicted_return=1, ras_count=0. Next cycle → 0x108, predicted_return=0.
- RAS overflow (RAS_DEPTH=4): five calls pushing return addresses A1..A5 → ras_count=4. Four rets yield A5, A4, A3, A2 in order. A fifth ret with count=0 → sequential, predicted_return=0.
- Stall vs redirect: stall=1 for 3 cycles at 0x200 → addr held, ret ignored, ras_count unchanged. In the same stall, redirect_valid=1 with target 0x301 → next addr 0x300, ia_plus4 0x304.
- Priority and wrap: redirect_valid, jump and ret asserted together → redirect target taken, no push/pop. Then jump=1 at 0x10 with offset 32'hFFFF_FFF0 → addr 0x0. Sequential from 32'hFFFF_FFFC → 0x0.
